// File: rtl/capsense_uart_reporter_if.sv
// Pin bundle between the CapSense button stage, the event reporter and the
// UART TX pin. The reporter sits on the slave side: it consumes the button
// vector and drives the TX line and the status flags.
interface capsense_uart_reporter_if #(
  parameter int N = 4
);
  logic [N-1:0] buttons_i;
  logic         tx_o;
  logic         busy_o;
  logic         fifo_full_o;

  modport master (
    output buttons_i,
    input  tx_o,
    input  busy_o,
    input  fifo_full_o
  );

  modport slave (
    input  buttons_i,
    output tx_o,
    output busy_o,
    output fifo_full_o
  );
endinterface

// File: rtl/capsense_uart_reporter.sv
// CapSense button event reporter.
// Registers the button vector, turns every level change into a pending flag,
// queues one {level, index} event per cycle (lowest index first) into a small
// FIFO, and sends each event as three ASCII bytes over an 8N1 UART:
// 'P'/'R', '0'+index, LF. Pending flags are held while the FIFO is full, so
// events are coalesced rather than lost.
module capsense_uart_reporter #(
  parameter int N          = 4,
  parameter int FREQUENCY  = 24,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  capsense_uart_reporter_if.slave    bus
);

  localparam int DIV = (FREQUENCY * 1000000) / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int PW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DIV_ONE   = CW'(1);
  localparam logic [CW-1:0] DIV_ZERO  = CW'(0);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_ZERO  = (PW + 1)'(0);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO  = PW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // ASCII byte number sel (0..2) of the line describing one event
  function automatic logic [7:0] event_byte(input logic [1:0] sel,
                                            input logic       level,
                                            input logic [3:0] idx);
    logic [7:0] b;
    case (sel)
      2'd0:    b = level ? 8'h50 : 8'h52;
      2'd1:    b = 8'h30 + {4'h0, idx};
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [N-1:0]    in_r;
  logic [N-1:0]    prev_r;
  logic [N-1:0]    pending_r;

  logic [4:0]      mem_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW:0]     count_r;
  logic            full_r;

  tx_state_t       state_r;
  logic [CW-1:0]   div_cnt_r;
  logic [2:0]      bit_cnt_r;
  logic [1:0]      byte_cnt_r;
  logic [7:0]      shift_r;
  logic            ev_level_r;
  logic [3:0]      ev_idx_r;
  logic            tx_r;
  logic            busy_r;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic [N-1:0]    chg_s;
  logic [N-1:0]    clr_mask_s;
  logic            found_s;
  logic [3:0]      sel_idx_s;
  logic            sel_level_s;
  logic            push_s;
  logic            pop_s;
  logic            empty_s;
  logic            last_tick_s;
  logic [4:0]      head_s;
  logic [PW:0]     count_nxt_s;

  assign chg_s       = in_r ^ prev_r;
  assign empty_s     = (count_r == CNT_ZERO);
  assign last_tick_s = (div_cnt_r == DIV_LAST);
  assign head_s      = mem_r[rd_ptr_r];
  assign push_s      = found_s & ~full_r;

  // Pick the lowest pending index and the level it carries right now
  always_comb begin
    found_s     = 1'b0;
    sel_idx_s   = 4'd0;
    sel_level_s = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      found_s     = found_s | pending_r[i];
      sel_idx_s   = pending_r[i] ? 4'(i) : sel_idx_s;
      sel_level_s = pending_r[i] ? prev_r[i] : sel_level_s;
    end
  end

  // One-hot clear of the pending flag whose event is written this cycle
  always_comb begin
    clr_mask_s = '0;
    for (int i = 0; i < N; i++) begin
      clr_mask_s[i] = push_s & (sel_idx_s == 4'(i));
    end
  end

  // Head of the FIFO is taken when idle, or straight from the last stop bit
  always_comb begin
    if (empty_s) begin
      pop_s = 1'b0;
    end else if (state_r == IDLE) begin
      pop_s = 1'b1;
    end else if ((state_r == STOP) && last_tick_s && (byte_cnt_r == 2'd2)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // ---------------------------------------------------------------------
  // Input stage: sample buttons, detect changes, keep pending flags
  // ---------------------------------------------------------------------
  // A change sets the flag; a write clears it; a new change in the same cycle wins
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      in_r      <= '0;
      prev_r    <= '0;
      pending_r <= '0;
    end else begin
      in_r      <= bus.buttons_i;
      prev_r    <= in_r;
      pending_r <= (pending_r & ~clr_mask_s) | chg_s;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------
  // Storage array; contents are don't-care while the entry is not valid
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {sel_level_s, sel_idx_s};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy and the registered full flag
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
    end else begin
      wr_ptr_r <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == DEPTH_C);
    end
  end

  // ---------------------------------------------------------------------
  // UART transmitter
  // ---------------------------------------------------------------------
  // Frame sequencer: start bit, 8 data bits LSB first, stop bit, 3 bytes per event
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r    <= IDLE;
      div_cnt_r  <= DIV_ZERO;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 2'd0;
      shift_r    <= 8'h00;
      ev_level_r <= 1'b0;
      ev_idx_r   <= 4'd0;
      tx_r       <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          div_cnt_r <= DIV_ZERO;
          if (pop_s) begin
            ev_level_r <= head_s[4];
            ev_idx_r   <= head_s[3:0];
            shift_r    <= event_byte(2'd0, head_s[4], head_s[3:0]);
            byte_cnt_r <= 2'd0;
            tx_r       <= 1'b0;
            state_r    <= START;
          end else begin
            tx_r <= 1'b1;
          end
        end

        START: begin
          if (last_tick_s) begin
            div_cnt_r <= DIV_ZERO;
            bit_cnt_r <= 3'd0;
            tx_r      <= shift_r[0];
            shift_r   <= {1'b0, shift_r[7:1]};
            state_r   <= DATA;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end

        DATA: begin
          if (last_tick_s) begin
            div_cnt_r <= DIV_ZERO;
            if (bit_cnt_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end

        STOP: begin
          if (last_tick_s) begin
            div_cnt_r <= DIV_ZERO;
            if (byte_cnt_r != 2'd2) begin
              // next byte of the same event, no gap
              byte_cnt_r <= byte_cnt_r + 2'd1;
              shift_r    <= event_byte(byte_cnt_r + 2'd1, ev_level_r, ev_idx_r);
              tx_r       <= 1'b0;
              state_r    <= START;
            end else if (pop_s) begin
              // next queued event starts right after this stop bit
              ev_level_r <= head_s[4];
              ev_idx_r   <= head_s[3:0];
              shift_r    <= event_byte(2'd0, head_s[4], head_s[3:0]);
              byte_cnt_r <= 2'd0;
              tx_r       <= 1'b0;
              state_r    <= START;
            end else begin
              tx_r    <= 1'b1;
              state_r <= IDLE;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end

        default: begin
          div_cnt_r <= DIV_ZERO;
          tx_r      <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Busy flag: transmitting or events still queued (one cycle behind)
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_r != IDLE) | ~empty_s;
    end
  end

  assign bus.tx_o        = tx_r;
  assign bus.busy_o      = busy_r;
  assign bus.fifo_full_o = full_r;

endmodule
